// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl: sequences writes into a ring of NUM_BUF line buffers and grants KERNEL_H-row column windows to the MAC datapath.
// Ports: clk/rst (sync, active-high); wr_valid/wr_ready handshake with we one-hot buffer enable and wr_addr column;
// rd_en/rd_valid handshake with oe window-buffer enables, rd_addr column and rd_row_sel (row 0 = oldest line);
// occ = completed unretired lines; frame_done pulses one cycle after the final retire of a frame.
// Optional CTRL_STALL_CNT_EN adds saturating 16-bit wr_stall_cnt / rd_stall_cnt.
module line_buffer_ctrl #(
  parameter int LINE_LEN = 8,
  parameter int KERNEL_H = 3,
  parameter int NUM_BUF = 4,
  parameter int IMG_H = 8,
  localparam int AW = $clog2(LINE_LEN),
  localparam int BW = $clog2(NUM_BUF),
  localparam int CW = $clog2(NUM_BUF + 1)
) (
  input logic clk,
  input logic rst,
  input logic wr_valid,
  output logic wr_ready,
  output logic [NUM_BUF-1:0] we,
  output logic [AW-1:0] wr_addr,
  input logic rd_en,
  output logic rd_valid,
  output logic [NUM_BUF-1:0] oe,
  output logic [AW-1:0] rd_addr,
  output logic [KERNEL_H*BW-1:0] rd_row_sel,
  output logic [CW-1:0] occ,
  output logic frame_done
`ifdef CTRL_STALL_CNT_EN
  ,
  output logic [15:0] wr_stall_cnt,
  output logic [15:0] rd_stall_cnt
`endif
);
  localparam int LW = IMG_H > 1 ? $clog2(IMG_H) : 1;
  logic [AW-1:0] wr_col, rd_col;
  logic [BW-1:0] wr_buf, rd_base;
  logic [LW-1:0] rd_line;
  logic wr_acc, rd_acc, line_done, row_end, last_row;
  logic [CW-1:0] retire;
  logic [BW-1:0] sel [KERNEL_H];
  int occ_n;
  assign wr_ready = occ < CW'(NUM_BUF);
  assign rd_valid = occ >= CW'(KERNEL_H);
  assign wr_acc = wr_valid & wr_ready;
  assign rd_acc = rd_en & rd_valid;
  assign line_done = wr_acc && wr_col == AW'(LINE_LEN - 1);
  assign row_end = rd_acc && rd_col == AW'(LINE_LEN - 1);
  assign last_row = rd_line == LW'(IMG_H - KERNEL_H);
  assign retire = row_end ? (last_row ? CW'(KERNEL_H) : CW'(1)) : '0;
  assign occ_n = int'(occ) + int'(line_done) - int'(retire);
  assign wr_addr = wr_col;
  assign rd_addr = rd_col;
  always_comb begin
    we = '0;
    we[wr_buf] = wr_acc;
  end
  always_comb begin
    oe = '0;
    rd_row_sel = '0;
    for (int r = 0; r < KERNEL_H; r++) begin
      sel[r] = BW'((int'(rd_base) + r) % NUM_BUF);
      oe[sel[r]] = rd_acc;
      rd_row_sel[r*BW +: BW] = sel[r];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_col <= '0;
      wr_buf <= '0;
      rd_col <= '0;
      rd_line <= '0;
      rd_base <= '0;
      occ <= '0;
      frame_done <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_col <= line_done ? '0 : wr_col + 1'b1;
        if (line_done) wr_buf <= wr_buf == BW'(NUM_BUF - 1) ? '0 : wr_buf + 1'b1;
      end
      if (rd_acc) rd_col <= row_end ? '0 : rd_col + 1'b1;
      if (row_end) begin
        rd_line <= last_row ? '0 : rd_line + 1'b1;
        rd_base <= BW'((int'(rd_base) + (last_row ? KERNEL_H : 1)) % NUM_BUF);
      end
      occ <= occ + CW'(line_done) - retire;
      frame_done <= row_end & last_row;
    end
  end
`ifdef CTRL_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_stall_cnt <= '0;
      rd_stall_cnt <= '0;
    end else begin
      if (wr_valid && !wr_ready && wr_stall_cnt != '1) wr_stall_cnt <= wr_stall_cnt + 1'b1;
      if (rd_en && !rd_valid && rd_stall_cnt != '1) rd_stall_cnt <= rd_stall_cnt + 1'b1;
    end
  end
`endif
  a_occ_range: assert property (@(posedge clk) disable iff (rst) occ_n >= 0 && occ_n <= NUM_BUF);
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// tb_line_buffer_ctrl: random and directed stimulus checked against a line-count reference model.
module tb_line_buffer_ctrl;
  localparam int L = 8, K = 3, NB = 4, IH = 8;
  localparam int AW = $clog2(L), BW = $clog2(NB), CW = $clog2(NB + 1);
  localparam int ROWS = IH - K + 1;
  logic clk = 0, rst = 1, wr_valid = 0, rd_en = 0;
  logic wr_ready, rd_valid, frame_done;
  logic [NB-1:0] we, oe;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [K*BW-1:0] rd_row_sel;
  logic [CW-1:0] occ;
`ifdef CTRL_STALL_CNT_EN
  logic [15:0] wr_stall_cnt, rd_stall_cnt;
  int m_wst, m_rst;
`endif
  int total = 0, bad = 0;
  int wcnt, rcnt, m_fd;
  line_buffer_ctrl #(.LINE_LEN(L), .KERNEL_H(K), .NUM_BUF(NB), .IMG_H(IH)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .we(we), .wr_addr(wr_addr),
    .rd_en(rd_en), .rd_valid(rd_valid), .oe(oe), .rd_addr(rd_addr), .rd_row_sel(rd_row_sel),
    .occ(occ), .frame_done(frame_done)
`ifdef CTRL_STALL_CNT_EN
    , .wr_stall_cnt(wr_stall_cnt), .rd_stall_cnt(rd_stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (wcnt=%0d rcnt=%0d)", tag, got, exp, wcnt, rcnt);
    end
  endtask
  function automatic int retired();
    int rows = rcnt / L;
    return (rows / ROWS) * IH + rows % ROWS;
  endfunction
  function automatic int m_occ();
    return wcnt / L - retired();
  endfunction
  task automatic step(input bit wv, input bit re, input bit r);
    int base, mo, sel, oem;
    bit wacc, racc;
    @(negedge clk);
    wr_valid = wv;
    rd_en = re;
    rst = r;
    #1;
    mo = m_occ();
    base = retired() % NB;
    wacc = wv && mo < NB;
    racc = re && mo >= K;
    sel = 0;
    oem = 0;
    for (int i = 0; i < K; i++) begin
      sel += ((base + i) % NB) << (i * BW);
      oem |= 1 << ((base + i) % NB);
    end
    chk("occ", 32'(occ), mo);
    chk("wr_ready", 32'(wr_ready), 32'(mo < NB));
    chk("rd_valid", 32'(rd_valid), 32'(mo >= K));
    chk("we", 32'(we), wacc ? 1 << ((wcnt / L) % NB) : 0);
    chk("wr_addr", 32'(wr_addr), wcnt % L);
    chk("oe", 32'(oe), racc ? oem : 0);
    chk("rd_addr", 32'(rd_addr), rcnt % L);
    chk("frame_done", 32'(frame_done), m_fd);
    if (mo >= K) chk("rd_row_sel", 32'(rd_row_sel), sel);
`ifdef CTRL_STALL_CNT_EN
    chk("wr_stall_cnt", 32'(wr_stall_cnt), m_wst);
    chk("rd_stall_cnt", 32'(rd_stall_cnt), m_rst);
`endif
    @(posedge clk);
    if (r) begin
      wcnt = 0;
      rcnt = 0;
      m_fd = 0;
`ifdef CTRL_STALL_CNT_EN
      m_wst = 0;
      m_rst = 0;
`endif
    end else begin
`ifdef CTRL_STALL_CNT_EN
      if (wv && mo >= NB && m_wst < 65535) m_wst++;
      if (re && mo < K && m_rst < 65535) m_rst++;
`endif
      m_fd = int'(racc && (rcnt + 1) % L == 0 && ((rcnt + 1) / L) % ROWS == 0);
      wcnt += int'(wacc);
      rcnt += int'(racc);
    end
  endtask
  int wp[6] = '{90, 20, 70, 100, 50, 95};
  int rp[6] = '{20, 90, 70, 100, 95, 50};
  initial begin
    wcnt = 0;
    rcnt = 0;
    m_fd = 0;
`ifdef CTRL_STALL_CNT_EN
    m_wst = 0;
    m_rst = 0;
`endif
    repeat (2) @(posedge clk);
    step(0, 0, 0);
    repeat (24) step(1, 0, 0);
    step(0, 1, 0);
    repeat (7) step(0, 1, 0);
    step(0, 0, 0);
    for (int p = 0; p < 6; p++)
      repeat (400) step($urandom_range(99) < wp[p], $urandom_range(99) < rp[p], 0);
    step(0, 0, 1);
    repeat (21) step(1, 0, 0);
    step(1, 1, 1);
    step(1, 0, 0);
    repeat (500) step($urandom_range(99) < 80, $urandom_range(99) < 80, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
